// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexer with fixed-select or
// round-robin arbitration and a 1-entry registered output stage.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_data      NUM_CH packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid     per-channel valid
//   in_ready     per-channel ready (combinational, one-hot or zero)
//   mode         0 = fixed select via sel, 1 = round-robin
//   sel          channel index used when mode = 0
//   out_data     registered output word
//   out_ch       channel index that supplied out_data
//   out_valid    output word valid
//   out_ready    consumer ready
module stream_mux_rr #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_load;
    logic              w_gnt_valid;
    logic [SEL_W-1:0]  w_gnt;
    logic [WIDTH-1:0]  w_gnt_data;
    logic [NUM_CH-1:0] w_in_ready;
    int                w_best;
    int                w_dist;

    // The output stage can take a word when empty or draining this cycle.
    assign w_load = ~r_out_valid | out_ready;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt       = '0;
        w_best      = NUM_CH;
        w_dist      = 0;
        if (!mode) begin
            // sel values at or beyond NUM_CH match no channel.
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt       = SEL_W'(i);
                end
            end
        end else begin
            // Distance of channel i from the slot after rr_ptr;
            // the valid channel with the smallest distance wins.
            for (int i = 0; i < NUM_CH; i++) begin
                w_dist = (i + NUM_CH - 1 - int'(r_rr_ptr)) % NUM_CH;
                if (in_valid[i] && w_dist < w_best) begin
                    w_best      = w_dist;
                    w_gnt_valid = 1'b1;
                    w_gnt       = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_in_ready[i] = rst_n & w_load & w_gnt_valid
                          & (w_gnt == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= SEL_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_rr_ptr <= w_gnt;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
